// File: rtl/div_pkg.sv
// Shared definitions for the sequential 2N-by-N restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_MAX_N = 32;

    // Sliced to 2N bits by the divider; all ones marks a divide by zero
    localparam logic [2*DIV_MAX_N-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] shl;

    assign shl   = {rem_i, bit_i};
    assign q_o   = (shl >= {1'b0, b_i});
    // The partial remainder stays below b, so the difference fits in N bits
    assign rem_o = q_o ? (shl[N-1:0] - b_i) : shl[N-1:0];

endmodule

// File: rtl/seq_div_2nxn.sv
// Sequential unsigned 2N/N divider with valid/ready handshakes,
// one quotient bit per cycle, and a fast path for division by zero.
module seq_div_2nxn
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quot,
    output logic [N-1:0]   rem,
    output logic           div_zero
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0]  CNT_MAX = CW'(2 * N - 1);
    localparam logic [2*N-1:0] DZ_Q    = DIV_ZERO_QUOT[2*N-1:0];

    div_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   prem_q;
    logic [2*N-1:0] dvd_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] qw_q;
    logic [2*N-1:0] quot_q;
    logic [N-1:0]   rem_q;
    logic           dz_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [N-1:0]   prem_d;
    logic           qbit_d;
    logic [2*N-1:0] qw_d;

    div_step #(.N(N)) u_step (
        .rem_i (prem_q),
        .bit_i (dvd_q[2*N-1]),
        .b_i   (b_q),
        .rem_o (prem_d),
        .q_o   (qbit_d)
    );

    assign qw_d = {qw_q[2*N-2:0], qbit_d};

    // Result registers only change on entry to DONE, so outputs stay
    // frozen while a new operation is being worked on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_q       <= '0;
            b_q         <= '0;
            qw_q        <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= a;
                        b_q        <= b;
                        prem_q     <= '0;
                        qw_q       <= '0;
                        cnt_q      <= CNT_MAX;
                        in_ready_q <= 1'b0;
                        if (b == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quot_q      <= DZ_Q;
                            rem_q       <= a[N-1:0];
                            dz_q        <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    dvd_q  <= {dvd_q[2*N-2:0], 1'b0};
                    qw_q   <= qw_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quot_q      <= qw_d;
                        rem_q       <= prem_d;
                        dz_q        <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div_2nxn.sv
// Directed and random checks of seq_div_2nxn (N=8) against a
// scoreboard of arithmetic results computed by the bench.
module tb_seq_div_2nxn;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] quot;
    logic [N-1:0]   rem;
    logic           div_zero;

    typedef struct {
        logic [2*N-1:0] q;
        logic [N-1:0]   r;
        logic           dz;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int vecs = 0;
    int miss = 0;

    seq_div_2nxn #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2*N-1:0] av, input logic [N-1:0] bv,
                         input int hold);
        exp_t e;
        int lat;
        logic [2*N-1:0] q0;
        logic [N-1:0] r0;
        logic stable;
        logic held;
        e.dz  = (bv == '0);
        e.q   = e.dz ? 16'hFFFF : av / {8'd0, bv};
        e.r   = e.dz ? av[N-1:0] : 8'(av % {8'd0, bv});
        e.lat = e.dz ? 1 : 2 * N + 1;
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("in_ready_idle", in_ready, 1);
        q0 = quot;
        r0 = rem;
        stable = 1'b1;
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(e);
        @(posedge clk); #1;
        lat = 1;
        // Operands are scrambled while busy; the DUT must ignore them
        a = 16'($urandom);
        b = 8'($urandom);
        while (!out_valid && lat < 40) begin
            if (quot !== q0 || rem !== r0) stable = 1'b0;
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, e.lat);
        chk("out_stable_busy", stable, 1);
        e = sb.pop_front();
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
        chk("div_zero", div_zero, e.dz);
        if (hold > 0) begin
            held = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || quot !== e.q || rem !== e.r)
                    held = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (in_ready) held = 1'b0;
            chk("held_done", held, 1);
        end
        @(posedge clk); #1;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_rise", in_ready, 1);
    endtask

    initial begin
        logic saw;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dz", div_zero, 0);

        do_op(16'd1000, 8'd7, 0);
        do_op(16'hFFFF, 8'd1, 0);
        do_op(16'hFFFF, 8'hFF, 0);
        do_op(16'd5, 8'd0, 0);
        do_op(16'd3, 8'd200, 10);
        do_op(16'd0, 8'd13, 0);

        a = 16'd1000;
        b = 8'd7;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_result", saw, 0);
        chk("abort_quot_clr", quot, 0);
        do_op(16'd100, 8'd9, 0);

        for (int i = 0; i < 1000; i++)
            do_op(16'($urandom), 8'($urandom_range(1, 255)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/seq_div_2nxn.md
SEQ_DIV_2NXN -- requirements
Module: seq_div_2nxn

Interface
REQ-001 SHALL have parameter N, default 8, divisor width; dividend and quotient width 2N.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  2N  unsigned dividend.
REQ-007 SHALL have port b  input  N  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port quot  output  2N  unsigned quotient.
REQ-011 SHALL have port rem  output  N  unsigned remainder.
REQ-012 SHALL have port div_zero  output  1  result came from b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept operands when in_valid && in_ready: latch a and b, clear the partial remainder, and load the iteration counter with 2N-1.
REQ-016 On acceptance with b != 0, SHALL go IDLE -> CALC.
REQ-017 On acceptance with b == 0, SHALL go directly IDLE -> DONE.
REQ-018 In CALC, SHALL perform one restoring step per cycle: shift the partial remainder (N+1 bits) left, inserting the dividend MSB.
REQ-019 In each CALC step, SHALL subtract b when the shifted remainder >= b, and shift the result bit into quot at the LSB.
REQ-020 SHALL perform exactly 2N CALC steps, then go CALC -> DONE.
REQ-021 SHALL give a result latency of 2N+1 cycles from the accepting edge to out_valid high (17 cycles for N=8); for b == 0 the latency is 1 cycle.
REQ-022 SHALL produce results with quot = floor(a/b) and rem = a mod b, exact and with no approximation.
REQ-023 SHALL force quot = all ones, rem = a[N-1:0] and div_zero = 1 when b == 0; div_zero = 0 otherwise.
REQ-024 SHALL hold quot, rem and div_zero stable in DONE until out_valid && out_ready.
REQ-025 SHALL go DONE -> IDLE on out_valid && out_ready; in_ready rises the following cycle, with no same-cycle re-accept.
REQ-026 SHALL ignore in_valid and any change on a/b outside IDLE.
REQ-027 SHALL produce quot = 0 and rem = a when a < b.
REQ-028 SHALL handle a = 0 normally: quot = 0, rem = 0, div_zero = 0.
REQ-029 SHALL not let quot/rem output values change while out_valid is low (internal working registers may differ).

Reset
REQ-030 SHALL, on rst, enter IDLE within one edge and clear the counter and partial remainder.
REQ-031 SHALL reset quot, rem and div_zero to 0, out_valid to 0, and in_ready to 1 the cycle after rst deasserts.
REQ-032 SHALL, when rst is asserted during CALC or DONE, abort the operation and never present its result.
REQ-033 SHALL let rst take priority over every handshake event in the same cycle.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE/CALC/DONE) and the divide-by-zero quotient constant in a shared package (div_pkg).
REQ-035 SHALL implement one combinational sub-module, div_step: inputs are partial remainder, next dividend bit and b; outputs are the new remainder and the quotient bit.
REQ-036 SHALL keep the FSM, counter and handshake logic in seq_div_2nxn.

Verification (N=8)
REQ-037 SHALL cover a=1000, b=7: out_valid 17 cycles after accept, quot=142, rem=6, div_zero=0.
REQ-038 SHALL cover a=16'hFFFF, b=1, followed by a=16'hFFFF, b=8'hFF: quot=16'hFFFF, rem=0; then quot=257, rem=0.
REQ-039 SHALL cover a=5, b=0: out_valid 1 cycle after accept, quot=16'hFFFF, rem=5, div_zero=1.
REQ-040 SHALL cover a=3, b=200 with out_ready held low 10 cycles: quot=0, rem=3, both held stable throughout; in_ready=0 until 1 cycle after out_ready rises.
REQ-041 SHALL cover rst pulsed at CALC step 8 of a=1000, b=7: no out_valid; in_ready=1 after reset; a new a=100, b=9 yields quot=11, rem=1.
REQ-042 SHALL cover 1000 random (a, b != 0) pairs back-to-back with out_ready=1: every result matches a/b and a%b, and every operation takes 17 cycles.
